uart_rx_fifo: RTL and testbench

//   UART receiver for the serial output of the USB-CDC bridge (the bridge's rx_o line).

---
 rtl/uart_rx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO and a valid/accept byte stream.
// Start bit is confirmed at mid-bit; data and stop bits are sampled one bit time apart.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 60000000,
  parameter int unsigned BAUDRATE   = 1000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       accept_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUDRATE;
  localparam int unsigned TickW      = $clog2(ClksPerBit);
  localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW       = AddrW + 1;

  localparam logic [TickW-1:0] TickLast = TickW'(ClksPerBit - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(ClksPerBit / 2 - 1);
  localparam logic [TickW-1:0] TickOne  = TickW'(1);
  localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
  localparam logic [PtrW-1:0]  PtrFull  = {1'b1, {AddrW{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  logic             rx_meta;
  logic             rx_s;
  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic             full;
  logic             empty;
  logic             pop;
  logic             stop_sample;
  logic             push;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign full        = (wr_ptr_q ^ rd_ptr_q) == PtrFull;
  assign empty       = wr_ptr_q == rd_ptr_q;
  assign pop         = valid_o & accept_i;
  assign stop_sample = (state_q == StStop) && (tick_q == TickLast);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push        = stop_sample && rx_s && (!full || pop);
  assign busy_o      = state_q != StIdle;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            tick_q  <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (tick_q == TickHalf) begin
            if (rx_s) begin
              state_q <= StIdle;
            end else begin
              tick_q  <= '0;
              bit_q   <= '0;
              state_q <= StData;
            end
          end else begin
            tick_q <= tick_q + TickOne;
          end
        end
        StData: begin
          if (tick_q == TickLast) begin
            shreg_q <= {rx_s, shreg_q[7:1]};
            tick_q  <= '0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            tick_q <= tick_q + TickOne;
          end
        end
        StStop: begin
          if (tick_q == TickLast) begin
            if (rx_s) begin
              overrun_o <= full && !pop;
              state_q   <= StIdle;
            end else begin
              frame_err_o <= 1'b1;
              state_q     <= StBreak;
            end
          end else begin
            tick_q <= tick_q + TickOne;
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= shreg_q;
    end
  end

  // The head register drops valid on a pop and reloads one cycle later, so a
  // held accept_i can never pop an entry that was not presented on data_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_o   <= '0;
      valid_o  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
        valid_o  <= 1'b0;
      end else if (!valid_o && !empty) begin
        valid_o <= 1'b1;
        data_o  <= mem_q[rd_ptr_q[AddrW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo at 60 clocks per bit,
// with a queue model of the received byte stream.
module tb_uart_rx_fifo;

  localparam int Cpb = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       accept = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int busy_cnt = 0;

  uart_rx_fifo #(
    .CLK_FREQ  (60000000),
    .BAUDRATE  (1000000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .rx_i       (rx),
    .data_o     (data),
    .valid_o    (valid),
    .accept_i   (accept),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = stop_bit;
    repeat (Cpb) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    int n = 0;
    while (valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_data"}, {24'd0, data}, {24'd0, exp});
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
  endtask

  initial begin
    #200000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t2_bytes [4];
    logic [7:0] exp_q [$];
    logic [7:0] b;
    int lat;
    int ferr0;
    int ovr0;
    int busy0;
    int ovr_exp;
    int npop;

    t2_bytes[0] = 8'h00;
    t2_bytes[1] = 8'hFF;
    t2_bytes[2] = 8'h55;
    t2_bytes[3] = 8'h3C;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte and its latency from the start edge.
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (valid !== 1'b1 && lat < 800) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("t1_latency_window", {31'd0, (lat >= 570 && lat <= 578)}, 32'd1);
    check("t1_ferr", ferr_cnt, 0);
    check("t1_ovr", ovr_cnt, 0);
    pop_check("t1", 8'hA5);
    repeat (3) @(negedge clk);
    check("t1_empty", {31'd0, valid}, 32'd0);

    // Fill the FIFO with back-to-back frames, then overrun it.
    for (int i = 0; i < 4; i++) send_byte(t2_bytes[i], 1'b1);
    repeat (10) @(negedge clk);
    check("t2_valid", {31'd0, valid}, 32'd1);
    check("t2_head", {24'd0, data}, 32'h00);
    ovr0 = ovr_cnt;
    send_byte(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    check("t3_overrun", ovr_cnt - ovr0, 1);
    check("t3_head_held", {24'd0, data}, 32'h00);
    for (int i = 0; i < 4; i++) pop_check("t2_pop", t2_bytes[i]);
    repeat (5) @(negedge clk);
    check("t2_drained", {31'd0, valid}, 32'd0);

    // Framing error followed by a long break.
    ferr0 = ferr_cnt;
    send_byte(8'h12, 1'b0);
    rx = 1'b0;
    repeat (20 * Cpb) @(negedge clk);
    check("t4_ferr_once", ferr_cnt - ferr0, 1);
    check("t4_busy_break", {31'd0, busy}, 32'd1);
    check("t4_no_push", {31'd0, valid}, 32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_idle", {31'd0, busy}, 32'd0);
    send_byte(8'h34, 1'b1);
    pop_check("t4", 8'h34);
    check("t4_ferr_total", ferr_cnt - ferr0, 1);

    // Short low glitch aborts in the start state.
    ferr0 = ferr_cnt;
    ovr0 = ovr_cnt;
    busy0 = busy_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t5_busy_len", {31'd0, (busy_cnt - busy0 >= 28 && busy_cnt - busy0 <= 32)}, 32'd1);
    check("t5_no_valid", {31'd0, valid}, 32'd0);
    check("t5_no_ferr", ferr_cnt - ferr0, 0);
    check("t5_no_ovr", ovr_cnt - ovr0, 0);

    // Reset in the middle of bit 4 of 0x77.
    b = 8'h77;
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = b[4];
    repeat (Cpb / 2) @(negedge clk);
    check("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_valid", {31'd0, valid}, 32'd0);
    check("t6_rst_data", {24'd0, data}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("t6_no_valid", {31'd0, valid}, 32'd0);
    send_byte(8'h99, 1'b1);
    pop_check("t6", 8'h99);

    // Random bytes against a queue model with random consumption.
    ovr0 = ovr_cnt;
    ovr_exp = 0;
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      if (exp_q.size() < 4) exp_q.push_back(b);
      else ovr_exp++;
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) begin
        if (exp_q.size() > 0) pop_check("rnd", exp_q.pop_front());
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    while (exp_q.size() > 0) pop_check("rnd_drain", exp_q.pop_front());
    repeat (5) @(negedge clk);
    check("rnd_overruns", ovr_cnt - ovr0, ovr_exp);
    check("rnd_empty", {31'd0, valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
